// File: rtl/async_fifo_lvl_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and
// parameter legality checks.
package fifo_pkg;

    // Pointer helpers work on a zero-extended 32-bit vector so one function
    // serves every pointer width; callers cast back to their own width.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 32'd1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // DEPTH is always 2**addr_bits, so a sane addr_bits range guarantees a
    // power-of-two depth; thresholds must lie inside 0..DEPTH.
    function automatic bit params_ok(input int addr_bits, input int sync_stages,
                                     input int af_thresh, input int ae_thresh);
        int depth;
        depth = 32'sd1 << addr_bits;
        return (addr_bits >= 32'sd1) && (addr_bits <= 32'sd30) &&
               (sync_stages >= 32'sd2) && (sync_stages <= 32'sd4) &&
               (af_thresh >= 32'sd0) && (af_thresh <= depth) &&
               (ae_thresh >= 32'sd0) && (ae_thresh <= depth);
    endfunction

endpackage

// File: rtl/async_fifo_lvl_if.sv
// Write/read handshake bundle of the dual-clock FIFO. The FIFO is the
// slave; the producer/consumer pair driving it is the master.
interface async_fifo_lvl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  wr_almost_full;
    logic [ADDR_BITS:0]    wr_level;
    logic                  wr_overflow;
    logic                  wr_ovf_clr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  rd_almost_empty;
    logic [ADDR_BITS:0]    rd_level;
    logic                  rd_underflow;
    logic                  rd_unf_clr;

    modport master (
        output wr_en, wr_data, wr_ovf_clr, rd_en, rd_unf_clr,
        input  wr_full, wr_almost_full, wr_level, wr_overflow,
               rd_data, rd_empty, rd_almost_empty, rd_level, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, wr_ovf_clr, rd_en, rd_unf_clr,
        output wr_full, wr_almost_full, wr_level, wr_overflow,
               rd_data, rd_empty, rd_almost_empty, rd_level, rd_underflow
    );
endinterface

// File: rtl/async_fifo_lvl_sync.sv
// Multi-flop synchroniser for a Gray-coded bus (only one bit changes per
// source update, so bitwise synchronisation is coherent).
module cdc_sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the incoming bus through STAGES flops in the destination domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with Gray pointers, per-domain fill levels, almost
// flags, sticky overflow/underflow and optional first-word-fall-through.
module async_fifo_lvl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0,
    parameter int AF_THRESH   = (32'sd1 << ADDR_BITS) - 32'sd2,
    parameter int AE_THRESH   = 2
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    async_fifo_lvl_if.slave  bus
);
    import fifo_pkg::*;

    localparam int DEPTH = 32'sd1 << ADDR_BITS;
    localparam int PTR_W = ADDR_BITS + 1;
    // Full when the write pointer sits exactly one lap ahead: top two Gray bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(2'b11) << (PTR_W - 2);
    localparam logic [PTR_W-1:0] AF_T      = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_T      = PTR_W'(AE_THRESH);
    localparam logic             AF_RST    = (AF_THRESH == 32'sd0);

    if (!params_ok(ADDR_BITS, SYNC_STAGES, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("async_fifo_lvl: illegal ADDR_BITS/SYNC_STAGES/threshold combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write domain state.
    logic [PTR_W-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] rq_gray_s, rq_bin_s, wr_level_q, wr_level_d;
    logic             wr_push_s, wr_full_q, wr_full_d, wr_af_q, wr_af_d, wr_ovf_q, wr_ovf_d;

    // Read domain state; ram_empty tracks the memory, rd_empty the visible output.
    logic [PTR_W-1:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0] wq_gray_s, wq_bin_s, rd_level_q, rd_level_d;
    logic             rd_pop_s, rd_fetch_s, rd_valid_d;
    logic             ram_empty_q, ram_empty_d, rd_empty_q, rd_empty_d;
    logic             rd_ae_q, rd_ae_d, rd_unf_q, rd_unf_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    cdc_sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rq_sync (
        .clk(wr_clk), .rst_n(wr_rst_n), .d_i(rd_gray_q), .q_o(rq_gray_s)
    );

    cdc_sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wq_sync (
        .clk(rd_clk), .rst_n(rd_rst_n), .d_i(wr_gray_q), .q_o(wq_gray_s)
    );

    // Write-side next state: pointer advance, full, level and overflow.
    always_comb begin
        wr_push_s  = bus.wr_en && !wr_full_q;
        wr_bin_d   = wr_bin_q + PTR_W'(wr_push_s);
        wr_gray_d  = PTR_W'(bin2gray(GRAY_MAX_W'(wr_bin_d)));
        rq_bin_s   = PTR_W'(gray2bin(GRAY_MAX_W'(rq_gray_s)));
        wr_full_d  = (wr_gray_d == (rq_gray_s ^ FULL_MASK));
        wr_level_d = wr_bin_d - rq_bin_s;
        wr_af_d    = (wr_level_d >= AF_T);
        if (bus.wr_en && wr_full_q) begin
            wr_ovf_d = 1'b1;
        end else if (bus.wr_ovf_clr) begin
            wr_ovf_d = 1'b0;
        end else begin
            wr_ovf_d = wr_ovf_q;
        end
    end

    // Write-side registers.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_q   <= {PTR_W{1'b0}};
            wr_gray_q  <= {PTR_W{1'b0}};
            wr_full_q  <= 1'b0;
            wr_af_q    <= AF_RST;
            wr_level_q <= {PTR_W{1'b0}};
            wr_ovf_q   <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            wr_full_q  <= wr_full_d;
            wr_af_q    <= wr_af_d;
            wr_level_q <= wr_level_d;
            wr_ovf_q   <= wr_ovf_d;
        end
    end

    // Storage array, written from the write domain only.
    always_ff @(posedge wr_clk) begin
        if (wr_push_s) begin
            mem_q[wr_bin_q[ADDR_BITS-1:0]] <= bus.wr_data;
        end
    end

    // Read-side next state. In FWFT mode the output register is refilled
    // whenever it is empty or being popped, giving one word per cycle.
    always_comb begin
        rd_pop_s = bus.rd_en && !rd_empty_q;
        if (FWFT != 0) begin
            rd_fetch_s = !ram_empty_q && (rd_empty_q || bus.rd_en);
        end else begin
            rd_fetch_s = rd_pop_s;
        end
        rd_bin_d    = rd_bin_q + PTR_W'(rd_fetch_s);
        rd_gray_d   = PTR_W'(bin2gray(GRAY_MAX_W'(rd_bin_d)));
        wq_bin_s    = PTR_W'(gray2bin(GRAY_MAX_W'(wq_gray_s)));
        ram_empty_d = (rd_gray_d == wq_gray_s);
        rd_level_d  = wq_bin_s - rd_bin_d;
        if (FWFT != 0) begin
            rd_valid_d = rd_fetch_s || (!rd_empty_q && !rd_pop_s);
            rd_empty_d = !rd_valid_d;
            rd_level_d = rd_level_d + PTR_W'(rd_valid_d);
        end else begin
            rd_valid_d = !ram_empty_d;
            rd_empty_d = ram_empty_d;
        end
        rd_ae_d = (rd_level_d <= AE_T);
        if (bus.rd_en && rd_empty_q) begin
            rd_unf_d = 1'b1;
        end else if (bus.rd_unf_clr) begin
            rd_unf_d = 1'b0;
        end else begin
            rd_unf_d = rd_unf_q;
        end
    end

    // Read-side registers, including the output data register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin_q    <= {PTR_W{1'b0}};
            rd_gray_q   <= {PTR_W{1'b0}};
            ram_empty_q <= 1'b1;
            rd_empty_q  <= 1'b1;
            rd_ae_q     <= 1'b1;
            rd_level_q  <= {PTR_W{1'b0}};
            rd_unf_q    <= 1'b0;
            rd_data_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            ram_empty_q <= ram_empty_d;
            rd_empty_q  <= rd_empty_d;
            rd_ae_q     <= rd_ae_d;
            rd_level_q  <= rd_level_d;
            rd_unf_q    <= rd_unf_d;
            if (rd_fetch_s) begin
                rd_data_q <= mem_q[rd_bin_q[ADDR_BITS-1:0]];
            end
        end
    end

    assign bus.wr_full         = wr_full_q;
    assign bus.wr_almost_full  = wr_af_q;
    assign bus.wr_level        = wr_level_q;
    assign bus.wr_overflow     = wr_ovf_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.rd_empty        = rd_empty_q;
    assign bus.rd_almost_empty = rd_ae_q;
    assign bus.rd_level        = rd_level_q;
    assign bus.rd_underflow    = rd_unf_q;
endmodule
